uart_comm_ctrl: RTL and testbench

Protocol controller that sits between the UART byte engines (`uart_rx`/`uart_tx`) and the hashing core inside the communication layer. It parses framed commands from the RX byte stream and assembles 44-byte work packets into a 352-bit job word. It buffers golden nonces from the hasher and arbitrates the single TX byte channel between nonce reports and command replies, always sending whole frames. It runs entirely in the `comm_clk` domain; crossing to `hash_clk` is done outside this block.

---
 rtl/uart_comm_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_uart_comm_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_comm_ctrl.sv
// -----------------------------------------------------------------------------
// uart_comm_ctrl
//   Protocol controller between the UART byte engines and the hashing core.
//   - Parses framed commands from the RX byte stream (0x01 job load, 0x02 ping).
//   - Assembles JOB_BYTES payload bytes into the job word (first byte -> job[7:0]).
//   - Buffers one golden nonce and reports it as 0x80 + 4 bytes LSB first.
//   - Arbitrates the TX byte channel: nonce > ack (0x81) > ping (0x82),
//     whole frames only, one TX_WAIT cycle after every write strobe.
//   Optional feature, macro UART_COMM_CTRL_DROP_CNT_EN: 8-bit saturating count
//   of dropped nonces, reported as 0x83 + count on command 0x03 (lowest priority).
//
// Ports
//   clk          in   UART clock (16x baud), the only clock
//   reset_n      in   asynchronous active-low reset
//   rx_flag      in   one-cycle strobe, rx_byte valid
//   rx_byte      in   received byte
//   tx_busy      in   UART transmitter busy
//   tx_we        out  one-cycle write strobe to the transmitter
//   tx_data      out  byte to transmit, valid while tx_we is high
//   nonce_valid  in   one-cycle strobe, nonce valid
//   nonce        in   golden nonce
//   job          out  last complete job (job[255:0] midstate, job[351:256] data)
//   job_valid    out  one-cycle pulse when job updates
// -----------------------------------------------------------------------------
module uart_comm_ctrl #(
  parameter int unsigned JOB_BYTES      = 44,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_flag,
  input  logic [7:0]               rx_byte,
  input  logic                     tx_busy,
  output logic                     tx_we,
  output logic [7:0]               tx_data,
  input  logic                     nonce_valid,
  input  logic [31:0]              nonce,
  output logic [JOB_BYTES*8-1:0]   job,
  output logic                     job_valid
);

  localparam int unsigned JOB_W = JOB_BYTES * 8;
  localparam int unsigned CNT_W = $clog2(JOB_BYTES + 1);

  typedef enum logic {IDLE, LOAD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;
  typedef enum logic [1:0] {FR_NONCE, FR_ACK, FR_PING, FR_STAT} frame_t;

  // ---------------------------------------------------------------------------
  // RX parser
  // ---------------------------------------------------------------------------
  rx_state_t        r_rx_state;
  logic [JOB_W-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_tmo;
  logic [JOB_W-1:0] r_job;
  logic             r_job_valid;

  logic             w_expired;
  logic             w_cmd;
  logic             w_start;
  logic             w_load_byte;
  logic             w_last;
  logic [JOB_W-1:0] w_shifted;
  logic             w_ping_set;
  logic             w_ack_set;

  // r_tmo counts idle cycles since the last rx_flag, so a byte arriving with a
  // gap of G cycles sees r_tmo == G-1; a gap of TIMEOUT_CYCLES hits the limit.
  assign w_expired   = (r_tmo >= (TIMEOUT_CYCLES - 16'd1));
  // A byte landing after the gap has expired is parsed as a fresh command.
  assign w_cmd       = rx_flag && ((r_rx_state == IDLE) || w_expired);
  assign w_start     = w_cmd && (rx_byte == 8'h01);
  assign w_ping_set  = w_cmd && (rx_byte == 8'h02);
  assign w_load_byte = rx_flag && (r_rx_state == LOAD) && !w_expired;
  assign w_shifted   = {rx_byte, r_shift[JOB_W-1:8]};
  assign w_last      = w_load_byte && (r_cnt == CNT_W'(JOB_BYTES - 1));
  assign w_ack_set   = w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state  <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_job       <= '0;
      r_job_valid <= 1'b0;
    end else begin
      r_job_valid <= 1'b0;

      if (rx_flag)
        r_tmo <= '0;
      else if (r_tmo != '1)
        r_tmo <= r_tmo + 16'd1;

      if (w_start) begin
        r_rx_state <= LOAD;
        r_cnt      <= '0;
      end else if ((r_rx_state == LOAD) && w_expired) begin
        r_rx_state <= IDLE;
      end else if (w_load_byte) begin
        r_shift <= w_shifted;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_job       <= w_shifted;
          r_job_valid <= 1'b1;
          r_rx_state  <= IDLE;
        end
      end
    end
  end

  assign job       = r_job;
  assign job_valid = r_job_valid;

  // ---------------------------------------------------------------------------
  // Pending flags and nonce buffer
  // ---------------------------------------------------------------------------
  logic        r_nonce_pend;
  logic [31:0] r_nonce;
  logic        r_ack_pend;
  logic        r_ping_pend;

  logic        w_nonce_clr;
  logic        w_ack_clr;
  logic        w_ping_clr;
  logic        w_nonce_cap;

  // The slot counts as free in the cycle its last byte is issued.
  assign w_nonce_cap = nonce_valid && (!r_nonce_pend || w_nonce_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nonce_pend <= 1'b0;
      r_nonce      <= '0;
      r_ack_pend   <= 1'b0;
      r_ping_pend  <= 1'b0;
    end else begin
      r_nonce_pend <= w_nonce_cap | (r_nonce_pend & ~w_nonce_clr);
      r_ack_pend   <= w_ack_set   | (r_ack_pend   & ~w_ack_clr);
      r_ping_pend  <= w_ping_set  | (r_ping_pend  & ~w_ping_clr);
      if (w_nonce_cap)
        r_nonce <= nonce;
    end
  end

`ifdef UART_COMM_CTRL_DROP_CNT_EN
  logic       r_stat_pend;
  logic [7:0] r_drop_cnt;
  logic       w_stat_set;
  logic       w_stat_clr;
  logic       w_drop;

  assign w_stat_set = w_cmd && (rx_byte == 8'h03);
  assign w_drop     = nonce_valid && !w_nonce_cap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_pend <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_stat_pend <= w_stat_set | (r_stat_pend & ~w_stat_clr);
      // A drop coinciding with the count byte starts the next count at one.
      if (w_stat_clr)
        r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
      else if (w_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // TX arbiter
  // ---------------------------------------------------------------------------
  tx_state_t r_tx_state;
  frame_t    r_kind;
  logic [2:0] r_idx;
  logic      r_frame_done;
  logic      r_tx_we;
  logic [7:0] r_tx_data;

  logic       w_any;
  frame_t     w_sel;
  frame_t     w_cur_kind;
  logic [2:0] w_cur_idx;
  logic [2:0] w_last_idx;
  logic       w_issue;
  logic       w_issue_last;
  logic [7:0] w_byte;

  always_comb begin
    w_any = 1'b1;
    w_sel = FR_ACK;
    if (r_nonce_pend)
      w_sel = FR_NONCE;
    else if (r_ack_pend)
      w_sel = FR_ACK;
    else if (r_ping_pend)
      w_sel = FR_PING;
`ifdef UART_COMM_CTRL_DROP_CNT_EN
    else if (r_stat_pend)
      w_sel = FR_STAT;
`endif
    else
      w_any = 1'b0;
  end

  // In TX_IDLE the first byte of the selected frame goes out directly, which
  // gives the two-cycle nonce_valid -> tx_we latency.
  assign w_cur_kind = (r_tx_state == TX_IDLE) ? w_sel : r_kind;
  assign w_cur_idx  = (r_tx_state == TX_IDLE) ? 3'd0 : r_idx;
  assign w_issue    = !tx_busy &&
                      (((r_tx_state == TX_IDLE) && w_any) || (r_tx_state == TX_SEND));

  always_comb begin
    w_last_idx = 3'd0;
    w_byte     = '0;
    unique case (w_cur_kind)
      FR_NONCE: begin
        w_last_idx = 3'd4;
        case (w_cur_idx)
          3'd0:    w_byte = 8'h80;
          3'd1:    w_byte = r_nonce[7:0];
          3'd2:    w_byte = r_nonce[15:8];
          3'd3:    w_byte = r_nonce[23:16];
          default: w_byte = r_nonce[31:24];
        endcase
      end
      FR_ACK:  w_byte = 8'h81;
      FR_PING: w_byte = 8'h82;
      FR_STAT: begin
        w_last_idx = 3'd1;
`ifdef UART_COMM_CTRL_DROP_CNT_EN
        w_byte = (w_cur_idx == 3'd0) ? 8'h83 : r_drop_cnt;
`else
        w_byte = 8'h83;
`endif
      end
      default: w_byte = '0;
    endcase
  end

  assign w_issue_last = w_issue && (w_cur_idx == w_last_idx);
  assign w_nonce_clr  = w_issue_last && (w_cur_kind == FR_NONCE);
  assign w_ack_clr    = w_issue_last && (w_cur_kind == FR_ACK);
  assign w_ping_clr   = w_issue_last && (w_cur_kind == FR_PING);
`ifdef UART_COMM_CTRL_DROP_CNT_EN
  assign w_stat_clr   = w_issue_last && (w_cur_kind == FR_STAT);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state   <= TX_IDLE;
      r_kind       <= FR_NONCE;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      r_tx_we      <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_tx_we <= 1'b0;
      unique case (r_tx_state)
        TX_IDLE: begin
          if (w_any) begin
            r_kind <= w_sel;
            if (w_issue) begin
              r_tx_we      <= 1'b1;
              r_tx_data    <= w_byte;
              r_idx        <= 3'd1;
              r_frame_done <= w_issue_last;
              r_tx_state   <= TX_WAIT;
            end else begin
              r_idx      <= 3'd0;
              r_tx_state <= TX_SEND;
            end
          end
        end
        TX_SEND: begin
          if (w_issue) begin
            r_tx_we      <= 1'b1;
            r_tx_data    <= w_byte;
            r_idx        <= r_idx + 3'd1;
            r_frame_done <= w_issue_last;
            r_tx_state   <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          r_tx_state <= r_frame_done ? TX_IDLE : TX_SEND;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx_we   = r_tx_we;
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_comm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_comm_ctrl
//   Directed plus randomized bench for uart_comm_ctrl. A small transmitter
//   model drives tx_busy; TX bytes and job_valid pulses are collected by
//   monitors and compared against expectations built from the protocol rules.
//   The byte-gap timeout is shortened so both sides of the boundary are cheap.
// -----------------------------------------------------------------------------
module tb_uart_comm_ctrl;

  localparam int unsigned JB  = 44;
  localparam logic [15:0] TMO = 16'd300;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         rx_flag;
  logic [7:0]   rx_byte;
  logic         tx_busy;
  logic         tx_we;
  logic [7:0]   tx_data;
  logic         nonce_valid;
  logic [31:0]  nonce;
  logic [351:0] job;
  logic         job_valid;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  uart_comm_ctrl #(.JOB_BYTES(JB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_flag(rx_flag), .rx_byte(rx_byte),
    .tx_busy(tx_busy), .tx_we(tx_we), .tx_data(tx_data),
    .nonce_valid(nonce_valid), .nonce(nonce),
    .job(job), .job_valid(job_valid)
  );

  // Transmitter model: busy for busy_len cycles, starting one cycle after tx_we.
  int unsigned busy_len = 2;
  int unsigned busy_cnt;
  logic        busy_q;
  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= 0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= tx_busy;
      if (tx_we)
        busy_cnt <= busy_len;
      else if (busy_cnt != 0)
        busy_cnt <= busy_cnt - 1;
    end
  end

  // Monitors: captured TX bytes, protocol violations, job_valid pulses.
  logic [7:0]  rxq[$];
  logic [7:0]  expq[$];
  logic        we_q = 1'b0;
  int unsigned viol = 0;
  int unsigned jv_cnt = 0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (tx_we) begin
        rxq.push_back(tx_data);
        if (we_q || busy_q) viol++;
      end
      if (job_valid) jv_cnt++;
    end
    we_q <= tx_we;
  end

  task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_flag = 1'b1;
    step(1);
    rx_flag = 1'b0;
  endtask

  task automatic send_nonce(input logic [31:0] v);
    nonce       = v;
    nonce_valid = 1'b1;
    step(1);
    nonce_valid = 1'b0;
  endtask

  task automatic push_nonce_frame(input logic [31:0] v);
    expq.push_back(8'h80);
    for (int i = 0; i < 4; i++) expq.push_back(v[8*i +: 8]);
  endtask

  // 0x01 followed by JB random bytes; byte i of the payload lands at job[8i+:8].
  task automatic load_job(input int unsigned max_gap, output logic [351:0] expj);
    logic [7:0] b;
    expj = '0;
    send_byte(8'h01);
    for (int i = 0; i < JB; i++) begin
      b = 8'($urandom);
      expj[8*i +: 8] = b;
      send_byte(b);
      if (max_gap > 1) step($urandom_range(max_gap - 1, 0));
    end
  endtask

  // Wait (bounded) for the expected TX bytes, idle a while to catch extras,
  // then compare count and contents.
  task automatic check_tx(input string tag, input int unsigned budget);
    int unsigned t = 0;
    while ((rxq.size() < expq.size()) && (t < budget)) begin
      step(1);
      t++;
    end
    step(busy_len * 2 + 20);
    chk({tag, " tx count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < rxq.size()) chk({tag, " tx byte"}, rxq[i], expq[i]);
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    logic [351:0] expj;
    logic [351:0] job_prev;
    logic [31:0]  nv;
    int unsigned  jv_base;
    int unsigned  k;
    logic         found;

    reset_n     = 1'b0;
    rx_flag     = 1'b0;
    rx_byte     = '0;
    nonce_valid = 1'b0;
    nonce       = '0;
    #1;
    chk("reset tx_we", tx_we, 1'b0);
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset job", job, '0);
    chk("reset job_valid", job_valid, 1'b0);
    step(3);
    reset_n = 1'b1;
    step(2);

    // Job load with bytes 0x00..0x2B
    jv_base = jv_cnt;
    expj    = '0;
    send_byte(8'h01);
    for (int i = 0; i < JB; i++) begin
      expj[8*i +: 8] = 8'(i);
      send_byte(8'(i));
    end
    chk("job_valid latency", job_valid, 1'b1);
    chk("job low byte", job[7:0], 8'h00);
    chk("job high byte", job[351:344], 8'h2B);
    chk("job word", job, expj);
    step(1);
    chk("job_valid single pulse", job_valid, 1'b0);
    chk("job_valid count", jv_cnt - jv_base, 1);
    expq.push_back(8'h81);
    check_tx("job ack", 200);

    // Nonce report with idle transmitter
    send_nonce(32'hDEADBEEF);
    chk("nonce tx_we early", tx_we, 1'b0);
    step(1);
    chk("nonce latency tx_we", tx_we, 1'b1);
    chk("nonce first byte", tx_data, 8'h80);
    push_nonce_frame(32'hDEADBEEF);
    check_tx("nonce frame", 200);

    // Overflow: second nonce while first pending is dropped
    busy_len = 4;
    send_nonce(32'h11223344);
    send_nonce(32'h55667788);
    push_nonce_frame(32'h11223344);
    check_tx("nonce overflow", 300);

`ifdef UART_COMM_CTRL_DROP_CNT_EN
    send_byte(8'h03);
    expq.push_back(8'h83);
    expq.push_back(8'h01);
    check_tx("drop count", 200);
`endif

    // Priority: nonce + ping in the same cycle, then a job completes mid-frame
    busy_len    = 30;
    jv_base     = jv_cnt;
    nv          = $urandom;
    nonce       = nv;
    nonce_valid = 1'b1;
    rx_byte     = 8'h02;
    rx_flag     = 1'b1;
    step(1);
    nonce_valid = 1'b0;
    rx_flag     = 1'b0;
    load_job(1, expj);
    push_nonce_frame(nv);
    expq.push_back(8'h81);
    expq.push_back(8'h82);
    check_tx("priority", 2000);
    chk("priority job", job, expj);
    chk("priority job_valid count", jv_cnt - jv_base, 1);

    // Timeout boundary: gap of TMO-1 keeps the partial job
    busy_len = 2;
    jv_base  = jv_cnt;
    expj     = '0;
    send_byte(8'h01);
    for (int i = 0; i < JB; i++) begin
      expj[8*i +: 8] = 8'($urandom);
      if (i == 10) step(TMO - 2);
      send_byte(expj[8*i +: 8]);
    end
    step(2);
    chk("gap below timeout job", job, expj);
    chk("gap below timeout job_valid", jv_cnt - jv_base, 1);
    expq.push_back(8'h81);
    check_tx("gap below timeout", 200);

    // Timeout: gap of TMO discards the partial job; 0x02 is then a ping
    jv_base  = jv_cnt;
    job_prev = job;
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    step(TMO - 1);
    send_byte(8'h02);
    step(5);
    chk("timeout job_valid", jv_cnt - jv_base, 0);
    chk("timeout job unchanged", job, job_prev);
    expq.push_back(8'h82);
    check_tx("timeout ping", 200);

    // Randomized jobs
    for (int it = 0; it < 3; it++) begin
      busy_len = $urandom_range(6, 0);
      jv_base  = jv_cnt;
      load_job(4, expj);
      step(2);
      chk("random job", job, expj);
      chk("random job_valid count", jv_cnt - jv_base, 1);
      expq.push_back(8'h81);
      check_tx("random job ack", 300);
    end

    // Randomized nonces with coalescing pings sent during the frame
    for (int it = 0; it < 4; it++) begin
      busy_len = $urandom_range(25, 10);
      nv       = $urandom;
      send_nonce(nv);
      k = $urandom_range(3, 1);
      for (int p = 0; p < k; p++) send_byte(8'h02);
      push_nonce_frame(nv);
      expq.push_back(8'h82);
      check_tx("random nonce", 1000);
    end

    // Reset during the third nonce byte
    busy_len = 8;
    nv       = $urandom;
    send_nonce(nv);
    found = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (tx_we && (rxq.size() == 3)) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
    chk("third nonce byte reached", found, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async reset tx_we", tx_we, 1'b0);
    chk("async reset tx_data", tx_data, 8'h00);
    chk("async reset job", job, '0);
    step(3);
    reset_n = 1'b1;
    step(100);
    chk("post reset tx count", rxq.size(), 3);
    chk("post reset tx_we", tx_we, 1'b0);
    chk("post reset tx_data", tx_data, 8'h00);
    chk("post reset job", job, '0);
    chk("post reset job_valid", job_valid, 1'b0);
    chk("tx protocol violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
